// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between a core (master) and the data memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_func3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I data memory responder: one outstanding load/store, fixed wait states, byte/half/word lanes.
// Optional macro MISALIGN_TRAP_EN: misaligned LH/LHU/SH/LW/SW report rsp_err and skip the access.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              accept, enter_resp;

  logic              we_p0;
  logic [AW+1:0]     addr_p0;
  logic [31:0]       wdata_p0;
  logic [2:0]        func3_p0;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [AW-1:0]     word_idx;
  logic [31:0]       cur_word;
  logic              misal;
  logic              wr_en;
  logic [31:0]       rdata_nxt;
  logic [31:0]       rdata_p1;

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] lo);
    logic [31:0] r;
    r = old;
    case (f3)
      3'd0:    r[{lo, 3'b000} +: 8]     = wd[7:0];
      3'd1:    r[{lo[1], 4'b0000} +: 16] = wd[15:0];
      3'd2:    r = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return w;
      3'd4:    return {24'd0, b};
      3'd5:    return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic we, input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'd1:    return lo[0];
      3'd2:    return lo != 2'b00;
      3'd5:    return !we && lo[0];
      default: return 1'b0;
    endcase
  endfunction
`endif

  // The counter reaches RESP one cycle after it hits zero, so WAIT_CYCLES=0 still
  // costs one cycle and acceptance-to-response is always WAIT_CYCLES+1 edges.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) begin
        accept    = 1'b1;
        state_nxt = WAIT;
        cnt_nxt   = 4'(WAIT_CYCLES);
      end
      WAIT: if (cnt == 4'd0) begin
        state_nxt  = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Stage p0: request captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      addr_p0  <= bus.req_addr[AW+1:0];
      wdata_p0 <= bus.req_wdata;
      func3_p0 <= bus.req_func3;
    end
  end

  assign word_idx = addr_p0[AW+1:2];
  assign cur_word = mem[word_idx];
`ifdef MISALIGN_TRAP_EN
  assign misal = misaligned(we_p0, func3_p0, addr_p0[1:0]);
`else
  assign misal = 1'b0;
`endif
  assign wr_en     = enter_resp && !rst && we_p0 && (func3_p0 <= 3'd2) && !misal;
  assign rdata_nxt = (we_p0 || misal) ? 32'd0 : load_ext(cur_word, func3_p0, addr_p0[1:0]);

  always_ff @(posedge clk) begin
    if (wr_en) mem[word_idx] <= store_merge(cur_word, wdata_p0, func3_p0, addr_p0[1:0]);
  end

  // Stage p1: response registered on entry to RESP and held until the handshake
  always_ff @(posedge clk) begin
    if (rst)             rdata_p1 <= 32'd0;
    else if (enter_resp) rdata_p1 <= rdata_nxt;
  end

`ifdef MISALIGN_TRAP_EN
  logic err_p1;
  always_ff @(posedge clk) begin
    if (rst)             err_p1 <= 1'b0;
    else if (enter_resp) err_p1 <= misal;
  end
  assign bus.rsp_err = err_p1;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_p1;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model with cycle-timestamped responses,
// directed literal checks and randomized load/store traffic.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int W     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  mb [1024];
  bit          m_busy  = 1'b0;
  bit          m_vld   = 1'b0;
  bit          m_fresh = 1'b1;
  logic [31:0] m_rdata = 32'd0;
  bit          m_err   = 1'b0;
  int          cyc     = 0;
  int          m_at    = 0;
  bit          p_we;
  logic [31:0] p_addr, p_wdata;
  logic [2:0]  p_f3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Little-endian byte-array view of the memory; 1 KiB window because of address aliasing.
  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, output logic [31:0] rd, output bit er);
    int a, b, v;
    bit mis;
    a   = int'(addr & 32'd1023);
    mis = 1'b0;
    rd  = 32'd0;
    er  = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || (f3 == 3'd5 && !we)) && (a % 2) != 0) mis = 1'b1;
    if (f3 == 3'd2 && (a % 4) != 0) mis = 1'b1;
`endif
    if (mis) begin
      er = 1'b1;
      return;
    end
    if (we) begin
      case (f3)
        3'd0: mb[a] = wd[7:0];
        3'd1: begin
          b = a - a % 2;
          mb[b] = wd[7:0];
          mb[b+1] = wd[15:8];
        end
        3'd2: begin
          b = a - a % 4;
          for (int k = 0; k < 4; k++) mb[b+k] = 8'(wd >> (8 * k));
        end
        default: ;
      endcase
    end else begin
      case (f3)
        3'd0, 3'd4: begin
          v = int'(mb[a]);
          if (f3 == 3'd0 && v >= 128) v = v - 256;
          rd = 32'(v);
        end
        3'd1, 3'd5: begin
          b = a - a % 2;
          v = int'(mb[b]) + 256 * int'(mb[b+1]);
          if (f3 == 3'd1 && v >= 32768) v = v - 65536;
          rd = 32'(v);
        end
        3'd2: begin
          b = a - a % 4;
          rd = 32'(mb[b]) + 32'(mb[b+1]) * 32'd256 + 32'(mb[b+2]) * 32'd65536
             + 32'(mb[b+3]) * 32'd16777216;
        end
        default: rd = 32'd0;
      endcase
    end
  endtask

  // Model advances on the rising edge; DUT outputs are compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy  = 1'b0;
        m_vld   = 1'b0;
        m_rdata = 32'd0;
        m_err   = 1'b0;
        m_fresh = 1'b1;
      end else if (!m_busy) begin
        if (bus.req_valid) begin
          m_busy  = 1'b1;
          m_at    = cyc + 1 + W;
          p_we    = bus.req_we;
          p_addr  = bus.req_addr;
          p_wdata = bus.req_wdata;
          p_f3    = bus.req_func3;
        end
      end else if (!m_vld) begin
        if (cyc == m_at) begin
          model_access(p_we, p_addr, p_wdata, p_f3, m_rdata, m_err);
          m_vld   = 1'b1;
          m_fresh = 1'b0;
        end
      end else if (bus.rsp_ready) begin
        m_vld  = 1'b0;
        m_busy = 1'b0;
      end
      @(negedge clk);
      chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
      if (m_vld || m_fresh) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end
    end
  end

  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] f3, input int hold, input bit junk,
                     output logic [31:0] rd, output bit er);
    int n;
    logic [31:0] first;
    rd = 32'd0;
    er = 1'b0;
    n  = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_func3 = f3;
    bus.rsp_ready = 1'($urandom);
    @(negedge clk);
    bus.req_valid = junk;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_func3 = 3'($urandom);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      bus.rsp_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(1 + W));
    if (!bus.rsp_valid) begin
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      return;
    end
    first = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rdata", bus.rsp_rdata, first);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit er;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    bus.req_func3 = 3'd0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    chk("reset_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      txn(1'b1, 32'(i * 4), $urandom, 3'd2, 0, 1'b0, rd, er);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 1'b0, rd, er);
    chk("sw_rdata_zero", rd, 32'd0);
    txn(1'b0, 32'h10, 32'd0, 3'd2, 0, 1'b0, rd, er);
    chk("lw_10", rd, 32'hDEADBEEF);
    txn(1'b1, 32'h13, 32'h00000080, 3'd0, 0, 1'b0, rd, er);
    txn(1'b0, 32'h13, 32'd0, 3'd0, 0, 1'b0, rd, er);
    chk("lb_13", rd, 32'hFFFFFF80);
    txn(1'b0, 32'h13, 32'd0, 3'd4, 0, 1'b0, rd, er);
    chk("lbu_13", rd, 32'h00000080);
    txn(1'b0, 32'h10, 32'd0, 3'd2, 0, 1'b0, rd, er);
    chk("lw_10_after_sb", rd, 32'h80ADBEEF);
    txn(1'b0, 32'h12, 32'd0, 3'd1, 0, 1'b0, rd, er);
    chk("lh_12", rd, 32'hFFFF80AD);
    txn(1'b0, 32'h12, 32'd0, 3'd5, 0, 1'b0, rd, er);
    chk("lhu_12", rd, 32'h000080AD);
    txn(1'b0, 32'h10, 32'd0, 3'd2, 5, 1'b1, rd, er);
    chk("lw_10_held", rd, 32'h80ADBEEF);
    txn(1'b1, 32'h10, 32'd0, 3'd3, 0, 1'b0, rd, er);
    chk("undef_store_rdata", rd, 32'd0);
    chk("undef_store_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'd0, 3'd2, 0, 1'b0, rd, er);
    chk("lw_10_after_undef", rd, 32'h80ADBEEF);
    txn(1'b0, 32'h10, 32'd0, 3'd6, 0, 1'b0, rd, er);
    chk("undef_load_rdata", rd, 32'd0);
    txn(1'b1, 32'h400, 32'h12345678, 3'd2, 0, 1'b0, rd, er);
    txn(1'b0, 32'h000, 32'd0, 3'd2, 0, 1'b0, rd, er);
    chk("lw_alias_0", rd, 32'h12345678);
    txn(1'b0, 32'h12, 32'd0, 3'd2, 0, 1'b0, rd, er);
`ifdef MISALIGN_TRAP_EN
    chk("lw_12_rdata", rd, 32'd0);
    chk("lw_12_err", 32'(er), 32'd1);
`else
    chk("lw_12_rdata", rd, 32'h80ADBEEF);
    chk("lw_12_err", 32'(er), 32'd0);
`endif

    txn(1'b1, 32'h20, 32'd0, 3'd2, 0, 1'b0, rd, er);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.req_func3 = 3'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rdata", bus.rsp_rdata, 32'd0);
    chk("midrst_err", 32'(bus.rsp_err), 32'd0);
    repeat (4) @(negedge clk);
    txn(1'b0, 32'h20, 32'd0, 3'd2, 0, 1'b0, rd, er);
    chk("lw_20_after_rst", rd, 32'd0);

    for (int i = 0; i < 200; i++)
      txn(1'($urandom), $urandom, $urandom, 3'($urandom), $urandom_range(0, 3),
          1'($urandom), rd, er);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
